// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subf_ser.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__subf_ser
// Brief    : Bit-serial unsigned subtractor, D = A - B computed LSB first
//            through a single full-subtractor slice and a borrow flop.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__subf_ser #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             SO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rs_d;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             borrow_q;
    logic             bo_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_a;
    logic             bit_b;
    logic             diff_d;
    logic             bout_d;
    logic             last_d;

    // Full-subtractor slice operating on the current LSBs
    assign bit_a  = sa_q[0];
    assign bit_b  = sb_q[0];
    assign diff_d = bit_a ^ bit_b ^ borrow_q;
    assign bout_d = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
    assign last_d = (cnt_q == CW'(WIDTH - 1));

    // Difference bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_rs_single
            assign rs_d = diff_d;
        end else begin : g_rs_multi
            assign rs_d = {diff_d, rs_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            rs_q     <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        sa_q     <= A;
                        sb_q     <= B;
                        rs_q     <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    rs_q     <= rs_d;
                    borrow_q <= bout_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        d_q     <= rs_d;
                        bo_q    <= bout_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign D    = d_q;
    assign BO   = bo_q;
    assign SO   = (state_q == S_RUN) ? diff_d : 1'b0;

endmodule
`default_nettype wire
